onewire_reset_sequencer: RTL
============================

// Module: onewire_reset_sequencer
// PURPOSE
//  Master-side 1-Wire reset/presence sequencer, directly upstream of the presence-wait stage.
//  On a start request it drives the reset pulse and hands the bus to the presence-wait stage.
//  It then captures that stage's verdict and enforces the recovery slot.
//  Its result gates the ROM/byte command stages.
//  Timing is in microseconds, derived from clk by an internal 1 us tick prescaler.
// PARAMETERS
//  CLK_DIV          1    clk cycles per 1 us tick (>=1)
//  RESET_LOW_US     480  reset pulse low time, us
//  PRES_TIMEOUT_US  120  max wait for done_wait_precence, us
//  RECOVERY_US      394  bus-released time after presence verdict, us
// PORTS
//  clk                 in   1  system clock
//  rst_n               in   1  async active-low reset
//  start               in   1  request a reset sequence (sampled in IDLE only)
//  bus                 in   1  synchronised 1-Wire line level
//  master_pull_low     out  1  1 = drive bus low (open-drain enable)
//  en_wait_precence    out  1  enable for the presence-wait stage
//  done_wait_precence  in   1  completion from the presence-wait stage
//  found_precence      in   1  presence verdict from that stage
//  busy                out  1  sequence in progress
//  done                out  1  1-cycle pulse at end of sequence
//  presence            out  1  latched verdict; valid from done until next start
//  error               out  1  latched: timeout (or bus short, see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; all outputs 0; tick prescaler and us counter cleared.
//  - Tick: prescaler counts 0..CLK_DIV-1 and asserts tick on the last count.
//    The prescaler clears on start acceptance, so the first tick comes CLK_DIV cycles later.
//  - us counter: 10 bits, loaded on each state entry; decrements on tick.
//  - IDLE: busy=0. start=1 -> next cycle: busy=1, presence=0, error=0.
//    * Default build: go to RST_LOW with master_pull_low=1.
//    * With the macro: go to CHECK instead.
//    * start while busy, or in the done-pulse cycle, is ignored (no queueing).
//  - RST_LOW: master_pull_low=1 for exactly RESET_LOW_US ticks (RESET_LOW_US*CLK_DIV cycles).
//    Next cycle: master_pull_low=0, en_wait_precence=1, state=WAIT_PRES.
//  - WAIT_PRES: en_wait_precence held 1.
//    done_wait_precence is qualified as a rising edge (registered previous value).
//    * On the edge: presence<=found_precence; en_wait_precence<=0; state RECOVER.
//    * Done already high on entry does not count as an edge.
//    * No edge within PRES_TIMEOUT_US ticks: en_wait_precence<=0; presence=0; error=1; state RECOVER.
//  - RECOVER: master_pull_low=0 for RECOVERY_US ticks.
//    Then done=1 for 1 cycle, busy=0, state IDLE.
//  - master_pull_low is never 1 while en_wait_precence is 1.
//  - Edge and timeout in the same cycle: the edge wins (verdict captured, error=0).
//  - rst_n mid-sequence: master_pull_low releases immediately (async).
//    No done pulse; presence and error clear.
// CONFIGURATION
//  ONEWIRE_BUS_SHORT_CHECK_EN defined:
//   - CHECK state, 1 tick, entered from IDLE on start.
//   - bus=1 at the tick -> RST_LOW.
//   - bus=0 -> error=1, presence=0, done pulse next cycle, back to IDLE.
//   - No reset pulse is driven when the bus is shorted.
//  Undefined: CHECK state is absent; start goes straight to RST_LOW; bus input is unused.
// TESTING  (CLK_DIV=1, defaults)
//  1. start pulse at cycle 0; model asserts done_wait_precence 86 cycles after en rises, found=1.
//     -> master_pull_low high cycles 1..480; en high from 481.
//     -> presence=1, error=0; done pulse 394 cycles after the done edge.
//  2. Same as 1 with found=0 -> presence=0, error=0, same timing.
//  3. done_wait_precence never rises.
//     -> en drops after 120 cycles; error=1, presence=0; done 394 cycles later.
//  4. rst_n low at cycle 200 of RST_LOW -> master_pull_low=0 same cycle; no done; busy=0.
//     Next start gives the full 480-cycle pulse.
//  5. start re-asserted during WAIT_PRES and in the done cycle -> ignored; exactly one done pulse.
//  6. Macro defined, bus held 0, start.
//     -> master_pull_low never asserts; error=1; done 2 cycles after start.

Source files
------------

// File: rtl/onewire_reset_sequencer.sv
// Master-side 1-Wire reset/presence sequencer.
// Drives the reset pulse, hands the bus to the presence-wait stage, captures
// its verdict (or times out), then enforces the recovery slot before done.
// Optional build macro: ONEWIRE_BUS_SHORT_CHECK_EN adds a 1-tick CHECK state
// that samples the bus before the reset pulse and aborts on a shorted line.
module onewire_reset_sequencer #(
    parameter int CLK_DIV         = 1,
    parameter int RESET_LOW_US    = 480,
    parameter int PRES_TIMEOUT_US = 120,
    parameter int RECOVERY_US     = 394
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bus,
    output logic master_pull_low,
    output logic en_wait_precence,
    input  logic done_wait_precence,
    input  logic found_precence,
    output logic busy,
    output logic done,
    output logic presence,
    output logic error
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [9:0]    LOAD_RST   = 10'(RESET_LOW_US);
    localparam logic [9:0]    LOAD_PRES  = 10'(PRES_TIMEOUT_US);
    localparam logic [9:0]    LOAD_REC   = 10'(RECOVERY_US);

`ifdef ONEWIRE_BUS_SHORT_CHECK_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RST_LOW,
        S_WAIT_PRES,
        S_RECOVER
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_LOW,
        S_WAIT_PRES,
        S_RECOVER
    } state_t;

    // Line level is only needed by the short check.
    logic unused_bus;
    assign unused_bus = bus;
`endif

    state_t          state;
    logic [PW-1:0]   presc;
    logic [9:0]      us_cnt;
    logic            done_wait_q;
    logic            tick;
    logic            done_edge;

    assign tick      = (presc == PRESC_LAST);
    assign done_edge = done_wait_precence && !done_wait_q;

    // Sequencer FSM with prescaler, us counter and registered outputs.
    // The prescaler is also cleared when the presence edge ends WAIT_PRES
    // off-tick, so the recovery slot always spans whole ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            presc            <= '0;
            us_cnt           <= '0;
            done_wait_q      <= 1'b0;
            master_pull_low  <= 1'b0;
            en_wait_precence <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            presence         <= 1'b0;
            error            <= 1'b0;
        end else begin
            done        <= 1'b0;
            done_wait_q <= done_wait_precence;
            if (state == S_IDLE || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start && !done) begin
                        busy     <= 1'b1;
                        presence <= 1'b0;
                        error    <= 1'b0;
                        presc    <= '0;
`ifdef ONEWIRE_BUS_SHORT_CHECK_EN
                        state    <= S_CHECK;
                        us_cnt   <= 10'd1;
`else
                        state           <= S_RST_LOW;
                        master_pull_low <= 1'b1;
                        us_cnt          <= LOAD_RST;
`endif
                    end
                end

`ifdef ONEWIRE_BUS_SHORT_CHECK_EN
                S_CHECK: begin
                    if (tick) begin
                        if (bus) begin
                            state           <= S_RST_LOW;
                            master_pull_low <= 1'b1;
                            us_cnt          <= LOAD_RST;
                        end else begin
                            error    <= 1'b1;
                            presence <= 1'b0;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end
                end
`endif

                S_RST_LOW: begin
                    if (tick) begin
                        if (us_cnt == 10'd1) begin
                            master_pull_low  <= 1'b0;
                            en_wait_precence <= 1'b1;
                            state            <= S_WAIT_PRES;
                            us_cnt           <= LOAD_PRES;
                        end else begin
                            us_cnt <= us_cnt - 10'd1;
                        end
                    end
                end

                S_WAIT_PRES: begin
                    // Edge takes priority over a coincident timeout.
                    if (done_edge) begin
                        presence         <= found_precence;
                        en_wait_precence <= 1'b0;
                        state            <= S_RECOVER;
                        us_cnt           <= LOAD_REC;
                        presc            <= '0;
                    end else if (tick) begin
                        if (us_cnt == 10'd1) begin
                            en_wait_precence <= 1'b0;
                            presence         <= 1'b0;
                            error            <= 1'b1;
                            state            <= S_RECOVER;
                            us_cnt           <= LOAD_REC;
                        end else begin
                            us_cnt <= us_cnt - 10'd1;
                        end
                    end
                end

                S_RECOVER: begin
                    if (tick) begin
                        if (us_cnt == 10'd1) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            us_cnt <= us_cnt - 10'd1;
                        end
                    end
                end

                default: begin
                    state            <= S_IDLE;
                    master_pull_low  <= 1'b0;
                    en_wait_precence <= 1'b0;
                    busy             <= 1'b0;
                end
            endcase
        end
    end

endmodule
